// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared pipeline constants: mul/div op codes, state enum, data width
package mips_pkg;

  localparam int MULDIV_DATA_WIDTH = 32;

  localparam logic [1:0] MULDIV_MULT  = 2'b00;
  localparam logic [1:0] MULDIV_MULTU = 2'b01;
  localparam logic [1:0] MULDIV_DIV   = 2'b10;
  localparam logic [1:0] MULDIV_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_FIX  = 2'd2
  } muldiv_state_e;

endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one shift-add multiply or restoring shift-subtract divide iteration
module muldiv_step #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2*DATA_WIDTH-1:0] i_acc,
  input  logic [DATA_WIDTH-1:0]   i_operand,
  input  logic                    i_div,
  output logic [2*DATA_WIDTH-1:0] o_acc,
  output logic                    o_qbit
);

  logic [DATA_WIDTH:0] w_sum;
  logic [DATA_WIDTH:0] w_diff;

  // Divide: the shifted partial remainder is always below twice the divisor, so the
  // MSB of the (DATA_WIDTH+1)-bit difference is a clean borrow flag.
  always_comb begin
    w_sum  = {1'b0, i_acc[2*DATA_WIDTH-1:DATA_WIDTH]} + {1'b0, i_operand};
    w_diff = i_acc[2*DATA_WIDTH-1:DATA_WIDTH-1] - {1'b0, i_operand};
    o_qbit = ~w_diff[DATA_WIDTH];
    if (i_div) begin
      if (o_qbit)
        o_acc = {w_diff[DATA_WIDTH-1:0], i_acc[DATA_WIDTH-2:0], 1'b0};
      else
        o_acc = {i_acc[2*DATA_WIDTH-2:0], 1'b0};
    end else begin
      if (i_acc[0])
        o_acc = {w_sum, i_acc[DATA_WIDTH-1:1]};
      else
        o_acc = {1'b0, i_acc[2*DATA_WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// rtl/ex_muldiv_unit.sv - EX-stage iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers
module ex_muldiv_unit
  import mips_pkg::*;
#(
  parameter int DATA_WIDTH = MULDIV_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] operand_a,
  input  logic [DATA_WIDTH-1:0] operand_b,
  input  logic                  hi_write,
  input  logic                  lo_write,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  flush,
  output logic                  busy,
  output logic                  done,
  output logic                  div_by_zero,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);

  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(DATA_WIDTH - 1);

  muldiv_state_e           r_state;
  logic [CW-1:0]           r_cnt;
  logic [2*DATA_WIDTH-1:0] r_acc;
  logic [DATA_WIDTH-1:0]   r_operand;
  logic [DATA_WIDTH-1:0]   r_a_orig;
  logic [DATA_WIDTH-1:0]   r_hi;
  logic [DATA_WIDTH-1:0]   r_lo;
  logic                    r_is_div;
  logic                    r_neg_q;
  logic                    r_neg_r;
  logic                    r_zero;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_dbz;

  logic                    w_signed;
  logic [DATA_WIDTH-1:0]   w_abs_a;
  logic [DATA_WIDTH-1:0]   w_abs_b;
  logic [2*DATA_WIDTH-1:0] w_acc_next;
  logic                    w_qbit;
  logic [2*DATA_WIDTH-1:0] w_prod;
  logic [DATA_WIDTH-1:0]   w_quot;
  logic [DATA_WIDTH-1:0]   w_rem;

  always_comb begin
    w_signed = (op == MULDIV_MULT) || (op == MULDIV_DIV);
    w_abs_a  = (w_signed && operand_a[DATA_WIDTH-1]) ? -operand_a : operand_a;
    w_abs_b  = (w_signed && operand_b[DATA_WIDTH-1]) ? -operand_b : operand_b;
    w_prod   = r_neg_q ? -r_acc : r_acc;
    w_quot   = r_neg_q ? -r_acc[DATA_WIDTH-1:0] : r_acc[DATA_WIDTH-1:0];
    w_rem    = r_neg_r ? -r_acc[2*DATA_WIDTH-1:DATA_WIDTH] : r_acc[2*DATA_WIDTH-1:DATA_WIDTH];
  end

  muldiv_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
    .i_acc     (r_acc),
    .i_operand (r_operand),
    .i_div     (r_is_div),
    .o_acc     (w_acc_next),
    .o_qbit    (w_qbit)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= MD_IDLE;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_operand <= '0;
      r_a_orig  <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_is_div  <= 1'b0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_zero    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_dbz     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_dbz  <= 1'b0;
      case (r_state)
        MD_IDLE: begin
          if (start) begin
            // Multiply keeps the multiplier in the low half; divide keeps the dividend there.
            r_is_div  <= op[1];
            r_acc     <= {{DATA_WIDTH{1'b0}}, (op[1] ? w_abs_a : w_abs_b)};
            r_operand <= op[1] ? w_abs_b : w_abs_a;
            r_a_orig  <= operand_a;
            r_neg_q   <= w_signed && (operand_a[DATA_WIDTH-1] ^ operand_b[DATA_WIDTH-1]);
            r_neg_r   <= w_signed && operand_a[DATA_WIDTH-1];
            r_zero    <= op[1] && (operand_b == '0);
            r_cnt     <= '0;
            r_busy    <= 1'b1;
            r_state   <= MD_RUN;
          end else begin
            if (hi_write) r_hi <= write_data;
            if (lo_write) r_lo <= write_data;
          end
        end
        MD_RUN: begin
          if (flush) begin
            r_busy  <= 1'b0;
            r_state <= MD_IDLE;
          end else begin
            r_acc <= {w_acc_next[2*DATA_WIDTH-1:1], (r_is_div ? w_qbit : w_acc_next[0])};
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == LAST_STEP) r_state <= MD_FIX;
          end
        end
        MD_FIX: begin
          if (!flush) begin
            if (!r_is_div) begin
              r_hi <= w_prod[2*DATA_WIDTH-1:DATA_WIDTH];
              r_lo <= w_prod[DATA_WIDTH-1:0];
            end else if (r_zero) begin
              r_hi <= r_a_orig;
              r_lo <= '1;
            end else begin
              r_hi <= w_rem;
              r_lo <= w_quot;
            end
            r_done <= 1'b1;
            r_dbz  <= r_zero;
          end
          r_busy  <= 1'b0;
          r_state <= MD_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= MD_IDLE;
        end
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign div_by_zero = r_dbz;
  assign hi          = r_hi;
  assign lo          = r_lo;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb/tb_ex_muldiv_unit.sv - directed self-checking bench for ex_muldiv_unit
module tb_ex_muldiv_unit;
  import mips_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] operand_a;
  logic [W-1:0] operand_b;
  logic         hi_write;
  logic         lo_write;
  logic [W-1:0] write_data;
  logic         flush;
  logic         busy;
  logic         done;
  logic         div_by_zero;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ex_muldiv_unit #(.DATA_WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .operand_a   (operand_a),
    .operand_b   (operand_b),
    .hi_write    (hi_write),
    .lo_write    (lo_write),
    .write_data  (write_data),
    .flush       (flush),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    start = 1'b1; op = o; operand_a = a; operand_b = b;
    tick();
    start = 1'b0;
  endtask

  // Called right after issue(); counts edges after the start edge until done, capped at 40.
  task automatic wait_done(output int edges, output int busy_cycles);
    edges = 0;
    busy_cycles = busy ? 1 : 0;
    while (!done && edges < 40) begin
      tick();
      edges++;
      if (busy) busy_cycles++;
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp_hi,
                        input logic [W-1:0] exp_lo, input logic exp_dbz);
    int edges;
    int bc;
    issue(o, a, b);
    wait_done(edges, bc);
    check({tag, " latency"}, edges, 33);
    check({tag, " hi"}, hi, exp_hi);
    check({tag, " lo"}, lo, exp_lo);
    check({tag, " dbz"}, div_by_zero, exp_dbz);
    check({tag, " busy_at_done"}, busy, 1'b0);
  endtask

  initial begin
    int edges;
    int bc;
    int seen;
    reset = 1'b1; start = 1'b0; op = 2'b00; operand_a = '0; operand_b = '0;
    hi_write = 1'b0; lo_write = 1'b0; write_data = '0; flush = 1'b0;
    tick(); tick();
    reset = 1'b0;

    check("rst busy", busy, 1'b0);
    check("rst done", done, 1'b0);
    check("rst dbz", div_by_zero, 1'b0);
    check("rst hi", hi, 32'h0);
    check("rst lo", lo, 32'h0);

    issue(MULDIV_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(edges, bc);
    check("multu_max latency", edges, 33);
    check("multu_max busy_cycles", bc, 33);
    check("multu_max hi", hi, 32'hFFFFFFFE);
    check("multu_max lo", lo, 32'h00000001);
    tick();
    check("multu_max done_fall", done, 1'b0);

    run_op("mult_neg", MULDIV_MULT, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
    run_op("divu_100_7", MULDIV_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    run_op("div_neg7_2", MULDIV_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    run_op("div_ovf", MULDIV_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0);
    run_op("divu_by0", MULDIV_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 1'b1);
    tick();
    check("divu_by0 dbz_fall", div_by_zero, 1'b0);

    // Flush in IDLE alongside start: start still accepted.
    flush = 1'b1;
    issue(MULDIV_MULTU, 32'd6, 32'd7);
    flush = 1'b0;
    check("idle_flush busy", busy, 1'b1);
    wait_done(edges, bc);
    check("idle_flush latency", edges, 33);
    check("idle_flush lo", lo, 32'd42);
    check("after_dbz dbz", div_by_zero, 1'b0);

    hi_write = 1'b1; lo_write = 1'b1; write_data = 32'h12345678;
    tick();
    hi_write = 1'b0; lo_write = 1'b0;
    check("mt hi", hi, 32'h12345678);
    check("mt lo", lo, 32'h12345678);
    check("mt busy", busy, 1'b0);

    issue(MULDIV_MULT, 32'd5, 32'd6);
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush busy", busy, 1'b0);
    check("flush done", done, 1'b0);
    check("flush hi", hi, 32'h12345678);
    check("flush lo", lo, 32'h12345678);
    seen = 0;
    repeat (40) begin
      tick();
      if (done) seen++;
    end
    check("flush no_done", seen, 0);

    lo_write = 1'b1; write_data = 32'hAAAA5555;
    issue(MULDIV_MULTU, 32'd1, 32'd1);
    lo_write = 1'b0;
    check("start_lo_write lo_kept", lo, 32'h12345678);
    wait_done(edges, bc);
    check("start_lo_write lo", lo, 32'd1);
    check("start_lo_write hi", hi, 32'd0);

    // Second start and MTHI while busy must not disturb the in-flight MULTU.
    issue(MULDIV_MULTU, 32'd3, 32'd4);
    repeat (4) tick();
    start = 1'b1; op = MULDIV_DIVU; operand_a = 32'd100; operand_b = 32'd7;
    hi_write = 1'b1; write_data = 32'hDEADBEEF;
    tick();
    start = 1'b0; hi_write = 1'b0;
    wait_done(edges, bc);
    check("busy_start latency", edges + 5, 33);
    check("busy_start lo", lo, 32'd12);
    check("busy_start hi", hi, 32'd0);

    issue(MULDIV_MULT, 32'h1234, 32'h5678);
    repeat (4) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst busy", busy, 1'b0);
    check("midrst done", done, 1'b0);
    check("midrst dbz", div_by_zero, 1'b0);
    check("midrst hi", hi, 32'h0);
    check("midrst lo", lo, 32'h0);
    run_op("post_rst", MULDIV_MULTU, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_unit.md
# ex_muldiv_unit

Iterative multiply/divide unit in the EX stage of the 5-stage MIPS pipeline, consuming operands and the mul/div request carried out of the ID/EX pipeline register. It executes MULT, MULTU, DIV and DIVU over DATA_WIDTH+1 cycles into architectural HI/LO registers. It also accepts MTHI/MTLO writes. While an operation is in flight it raises `busy`, which the hazard unit uses to stall IF/ID/ID-EX.

## Interface
- DATA_WIDTH, 32, operand/HI/LO width; iteration count equals DATA_WIDTH
- clk  in  1  pipeline clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; clears all state and outputs
- start  in  1  request a mul/div this cycle (from ID/EX stage decode)
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU (shared package constants)
- operand_a  in  DATA_WIDTH  rs value (forwarded); multiplicand / dividend
- operand_b  in  DATA_WIDTH  rt value (forwarded); multiplier / divisor
- hi_write  in  1  MTHI: write `write_data` to HI
- lo_write  in  1  MTLO: write `write_data` to LO
- write_data  in  DATA_WIDTH  MTHI/MTLO data
- flush  in  1  abort in-flight operation (branch/exception squash)
- busy  out  1  operation in flight; stall request
- done  out  1  one-cycle pulse when HI/LO receive a result
- div_by_zero  out  1  valid with `done`; divisor was zero
- hi  out  DATA_WIDTH  HI register
- lo  out  DATA_WIDTH  LO register

## Operation
- FSM states: IDLE, RUN, FIX.
- IDLE + start: latch |operand_a|, |operand_b| (absolute values only for MULT/DIV), the result sign flags, the op, and a zero-divisor flag. Clear the iteration counter. Go to RUN.
- RUN: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle on a 2×DATA_WIDTH accumulator. After DATA_WIDTH steps go to FIX.
- FIX: apply sign correction and write HI/LO, pulse done, return to IDLE.
- Multiply: {HI,LO} = 2×DATA_WIDTH product. Signed product is negated when the operand signs differ.
- Divide: LO = quotient, HI = remainder. Signed: the quotient is negated when the signs differ; the remainder takes the dividend's sign. All arithmetic is modulo 2^DATA_WIDTH, so 0x80000000 / 0xFFFFFFFF (DIV) gives LO=0x80000000, HI=0.
- Divisor zero (DIV or DIVU): HI=operand_a as latched (original, unsigned-interpreted), LO=all ones. div_by_zero=1 with done. Same latency as a normal divide.
- start while busy: ignored. hi_write/lo_write while busy: ignored.
- In IDLE, start and hi_write/lo_write in the same cycle: start wins and the writes are dropped. hi_write and lo_write together: both applied.
- flush in RUN or FIX: return to IDLE at that edge. HI/LO keep their prior values, no done. flush has priority over FIX completion. flush in IDLE: no effect; a same-cycle start is still accepted.
- reset: state IDLE. busy, done, div_by_zero, hi, lo, counter and accumulators all 0. Reset mid-operation discards the operation.

## Timing
- start sampled at edge E (IDLE) → busy=1 after E.
- RUN steps occupy edges E+1..E+DATA_WIDTH. FIX completes at edge E+DATA_WIDTH+1 (E+33 for 32-bit).
- After E+33: hi/lo hold the result, done=1 and busy=0 for exactly one cycle. A new start may be sampled at E+34.
- busy is high for DATA_WIDTH+1 cycles. done and div_by_zero are registered and fall at the next edge.
- MTHI/MTLO in IDLE: hi/lo updated at the sampling edge, visible next cycle. busy is unaffected.
- busy is a registered output. The hazard unit ORs it with a combinational "start && IDLE" term; that term is not this block's job.

## Structure
- Shared package mips_pkg: MULDIV_MULT/MULTU/DIV/DIVU op constants, the muldiv state enum (IDLE, RUN, FIX), and the DATA_WIDTH default.
- One natural sub-module: muldiv_step. It is combinational and takes accumulator, operand and mode to produce the next accumulator and quotient bit. It is instantiated once and drives the RUN register update.
- FSM, counter, sign flags and HI/LO registers live in ex_muldiv_unit.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001. done exactly 33 edges after start, busy high 33 cycles.
- MULT 0xFFFFFFFD (−3) × 7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB. DIVU 100/7 → LO=14, HI=2.
- DIV 0xFFFFFFF9 (−7) / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- DIVU 5/0 → HI=5, LO=0xFFFFFFFF, div_by_zero=1 with done. The next normal op shows div_by_zero=0.
- Start a MULT with HI=LO=0x12345678 preloaded via MTHI/MTLO. Assert flush on the 10th busy cycle → busy=0 next cycle, HI/LO unchanged, no done. A second start mid-op is ignored. Start with lo_write in IDLE drops the write.
- Reset asserted on the 5th busy cycle → after the edge busy=done=div_by_zero=0, hi=lo=0, state IDLE. A fresh MULTU 3×4 then gives LO=12, HI=0.
